// File: rtl/fb_pattern_slave.sv
// Framebuffer read slave that returns procedurally generated RGB332 test patterns.
// Latency: each accepted read returns exactly LATENCY cycles later, in acceptance order.
// Backpressure: fb_waitrequest is high while MAX_PENDING reads are outstanding, or in reset.
// Optional build macro FB_PATTERN_STALL_EN adds pseudo-random LFSR stalls on fb_waitrequest.
module fb_pattern_slave #(
  parameter int unsigned FB_BEGIN    = 262144,
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned MAX_PENDING = 2
) (
  input  logic        memory_clock,
  input  logic        reset_n,
  input  logic [29:0] fb_address,
  input  logic        fb_read,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  solid_color,
  output logic        fb_waitrequest,
  output logic [31:0] fb_readdata,
  output logic        fb_readdatavalid,
  output logic [31:0] reads_served,
  output logic        misaligned
);

  localparam logic [29:0] C_BEGIN   = 30'(FB_BEGIN);
  localparam logic [3:0]  C_MAX_PND = 4'(MAX_PENDING);

  logic               w_accept;
  logic               w_ret;
  logic               w_full;
  logic               w_stall;
  logic [29:0]        w_offset;
  logic [7:0]         w_base;
  logic [2:0]         w_bar;
  logic               w_chk;
  logic [31:0]        w_pix;
  logic               w_unused_bits;

  logic [LATENCY-1:0] r_vld;
  logic [31:0]        r_dat [LATENCY];
  logic [3:0]         r_pending;
  logic [31:0]        r_served;
  logic               r_mis;

  // Offset within the framebuffer; 30-bit wrap makes addresses below the base legal.
  assign w_offset      = fb_address - C_BEGIN;
  assign w_base        = {w_offset[7:2], 2'b00};
  assign w_bar         = w_offset[10:8];
  assign w_chk         = w_offset[4] ^ w_offset[12];
  assign w_unused_bits = ^{w_offset[29:13], w_offset[11], w_offset[1:0]};

  // Pixel generator: four bytes, leftmost byte is the lowest address.
  always_comb begin
    w_pix = 32'h0;
    case (pattern_sel)
      2'd0:    w_pix = {w_base, w_base | 8'd1, w_base | 8'd2, w_base | 8'd3};
      2'd1:    w_pix = {4{w_bar, w_bar, w_bar[2:1]}};
      2'd2:    w_pix = {4{w_chk ? 8'hFF : 8'h00}};
      default: w_pix = {4{solid_color}};
    endcase
  end

  // A read counts as pending until it enters the final (output) stage, so a slot
  // is freed in the same cycle its data appears and full-rate streaming is possible.
  generate
    if (LATENCY >= 2) begin : g_ret_pipe
      assign w_ret = r_vld[LATENCY-2];
    end else begin : g_ret_direct
      assign w_ret = w_accept;
    end
  endgenerate

  assign w_full         = (r_pending >= C_MAX_PND);
  assign fb_waitrequest = ~reset_n | w_full | w_stall;
  assign w_accept       = fb_read & ~fb_waitrequest;

`ifdef FB_PATTERN_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16/14/13/11; free-running stall source.
  always_ff @(posedge memory_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // Delay line: each stage loads only when a valid word moves in, so the last
  // stage keeps the most recently returned word between valid pulses.
  always_ff @(posedge memory_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_dat[i] <= 32'h0;
    end else begin
      r_vld[0] <= w_accept;
      if (w_accept) r_dat[0] <= w_pix;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end

  // Outstanding-read counter; simultaneous accept and retire cancel out.
  always_ff @(posedge memory_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 4'd0;
    end else begin
      case ({w_accept, w_ret})
        2'b10:   r_pending <= r_pending + 4'd1;
        2'b01:   r_pending <= r_pending - 4'd1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Returned-word counter (wraps naturally) and sticky misaligned-access flag.
  always_ff @(posedge memory_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_served <= 32'h0;
      r_mis    <= 1'b0;
    end else begin
      if (r_vld[LATENCY-1]) r_served <= r_served + 32'd1;
      if (w_accept && (fb_address[1:0] != 2'b00)) r_mis <= 1'b1;
    end
  end

  assign fb_readdata      = r_dat[LATENCY-1];
  assign fb_readdatavalid = r_vld[LATENCY-1];
  assign reads_served     = r_served;
  assign misaligned       = r_mis;

endmodule

// File: tb/tb_fb_pattern_slave.sv
module tb_fb_pattern_slave;

  localparam int LAT  = 3;
  localparam int MAXP = 2;
  localparam int BASE = 262144;

  logic        memory_clock = 1'b0;
  logic        reset_n;
  logic [29:0] fb_address;
  logic        fb_read;
  logic [1:0]  pattern_sel;
  logic [7:0]  solid_color;
  logic        fb_waitrequest;
  logic [31:0] fb_readdata;
  logic        fb_readdatavalid;
  logic [31:0] reads_served;
  logic        misaligned;

  fb_pattern_slave #(.FB_BEGIN(BASE), .LATENCY(LAT), .MAX_PENDING(MAXP)) dut (
    .memory_clock     (memory_clock),
    .reset_n          (reset_n),
    .fb_address       (fb_address),
    .fb_read          (fb_read),
    .pattern_sel      (pattern_sel),
    .solid_color      (solid_color),
    .fb_waitrequest   (fb_waitrequest),
    .fb_readdata      (fb_readdata),
    .fb_readdatavalid (fb_readdatavalid),
    .reads_served     (reads_served),
    .misaligned       (misaligned)
  );

  always #5 memory_clock = ~memory_clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Expected pixel word, derived directly from the pattern rules with integer math.
  function automatic logic [31:0] pix(input logic [29:0] addr, input logic [1:0] sel, input logic [7:0] c);
    logic [29:0] off;
    logic [31:0] w;
    int o, b, bb;
    off = addr - 30'(BASE);
    o   = int'({2'b00, off});
    o   = o - (o % 4);
    w   = 32'h0;
    for (int k = 0; k < 4; k++) begin
      case (sel)
        2'd0: b = (o + k) % 256;
        2'd1: begin bb = (o / 256) % 8; b = bb * 32 + bb * 4 + bb / 2; end
        2'd2: b = (((o / 16) % 2) != ((o / 4096) % 2)) ? 255 : 0;
        default: b = int'(c);
      endcase
      w = (w << 8) | 32'(b);
    end
    return w;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_ret = 0;
  int          last_acc_cyc = 0;
  int          last_ret_cyc = 0;
  logic [31:0] last_ret_dat = 32'h0;
  logic [31:0] m_last = 32'h0;
  logic [31:0] m_served = 32'h0;
  logic        m_mis = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;

  // Cycle-by-cycle comparison of every DUT output against the scoreboard model.
  always @(negedge memory_clock) begin
    int   nfut;
    logic wexp;
    logic vexp;
    if (!reset_n) begin
      chk("reset_waitrequest", {31'b0, fb_waitrequest}, 32'd1);
      chk("reset_valid", {31'b0, fb_readdatavalid}, 32'd0);
      chk("reset_readdata", fb_readdata, 32'h0);
      chk("reset_served", reads_served, 32'h0);
      chk("reset_misaligned", {31'b0, misaligned}, 32'd0);
      q.delete();
      m_last   = 32'h0;
      m_served = 32'h0;
      m_mis    = 1'b0;
      m_lfsr   = 16'hACE1;
    end else begin
      nfut = 0;
      foreach (q[i]) if (q[i].due > cyc) nfut++;
      chk("pending_bound", 32'(nfut), 32'(nfut <= MAXP ? nfut : MAXP));
      wexp = (nfut >= MAXP);
`ifdef FB_PATTERN_STALL_EN
      wexp = wexp | (m_lfsr[1:0] == 2'b00);
`endif
      m_lfsr = lstep(m_lfsr);
      chk("waitrequest", {31'b0, fb_waitrequest}, {31'b0, wexp});
      chk("reads_served", reads_served, m_served);
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      vexp = (q.size() > 0) && (q[0].due == cyc);
      chk("readdatavalid", {31'b0, fb_readdatavalid}, {31'b0, vexp});
      if (vexp) begin
        if (fb_readdatavalid) chk("readdata", fb_readdata, q[0].dat);
        m_last = q[0].dat;
        void'(q.pop_front());
      end else begin
        chk("readdata_hold", fb_readdata, m_last);
      end
      if (fb_readdatavalid) begin
        m_served++;
        n_ret++;
        last_ret_cyc = cyc;
        last_ret_dat = fb_readdata;
      end
      if (fb_read && !fb_waitrequest) begin
        q.push_back('{due: cyc + LAT, dat: pix(fb_address, pattern_sel, solid_color)});
        if (fb_address[1:0] != 2'b00) m_mis = 1'b1;
        last_acc_cyc = cyc;
      end
    end
    cyc++;
  end

  // Present a read and hold it until accepted; leaves fb_read high on return.
  task automatic issue(input logic [29:0] a, input logic [1:0] s, input logic [7:0] c, output int nwait);
    logic acc;
    fb_address  = a;
    pattern_sel = s;
    solid_color = c;
    fb_read     = 1'b1;
    nwait       = 0;
    acc         = 1'b0;
    while (!acc && nwait < 200) begin
      @(negedge memory_clock);
      acc = !fb_waitrequest;
      @(posedge memory_clock);
      #1;
      if (!acc) nwait++;
    end
    if (!acc) chk("accept_timeout", 32'(nwait), 32'd0);
  endtask

  task automatic drain();
    fb_read = 1'b0;
    repeat (LAT + 3) @(posedge memory_clock);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    fb_read = 1'b0;
    repeat (2) @(posedge memory_clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, tot, r0;
    reset_n     = 1'b0;
    fb_read     = 1'b0;
    fb_address  = 30'h0;
    pattern_sel = 2'd0;
    solid_color = 8'h00;
    repeat (3) @(posedge memory_clock);
    #1;
    reset_n = 1'b1;

    // Single ramp read right after reset release.
    issue(30'(BASE), 2'd0, 8'h00, nw);
    chk("first_accept_no_wait", 32'(nw), 32'd0);
    drain();
    chk("ramp_data", last_ret_dat, 32'h00010203);
    chk("ramp_latency", 32'(last_ret_cyc - last_acc_cyc), 32'd3);
    chk("ramp_served", reads_served, 32'd1);

    // Bars and checker patterns.
    issue(30'(BASE + 'h300), 2'd1, 8'h00, nw);
    drain();
    chk("bars_data", last_ret_dat, 32'h6D6D6D6D);
    issue(30'(BASE + 'h10), 2'd2, 8'h00, nw);
    drain();
    chk("checker_on", last_ret_dat, 32'hFFFFFFFF);
    issue(30'(BASE + 'h1010), 2'd2, 8'h00, nw);
    drain();
    chk("checker_off", last_ret_dat, 32'h00000000);

    // Address below the base wraps around.
    issue(30'(BASE - 4), 2'd0, 8'h00, nw);
    drain();
    chk("wrap_below_base", last_ret_dat, 32'hFCFDFEFF);

    // Held request stream of 8 consecutive words.
    r0  = n_ret;
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      issue(30'(BASE + 4 * i), 2'd0, 8'h00, nw);
      tot += nw;
    end
    drain();
    chk("burst_returns", 32'(n_ret - r0), 32'd8);
    chk("burst_last_word", last_ret_dat, 32'h1C1D1E1F);
    chk("burst_backpressure", 32'(tot > 0), 32'd1);

    // Solid colour, misaligned, and stickiness of the flag.
    issue(30'(BASE + 2), 2'd3, 8'hE3, nw);
    drain();
    chk("solid_data", last_ret_dat, 32'hE3E3E3E3);
    chk("misaligned_set", {31'b0, misaligned}, 32'd1);
    issue(30'(BASE + 8), 2'd0, 8'h00, nw);
    drain();
    chk("misaligned_sticky", {31'b0, misaligned}, 32'd1);
    chk("ramp_after_solid", last_ret_dat, 32'h08090A0B);

    // Reset with two reads in flight.
    issue(30'(BASE + 'h40), 2'd0, 8'h00, nw);
    issue(30'(BASE + 'h44), 2'd0, 8'h00, nw);
    fb_read = 1'b0;
    r0 = n_ret;
    do_reset();
    repeat (8) @(posedge memory_clock);
    #1;
    chk("no_stale_valid", 32'(n_ret - r0), 32'd0);
    chk("served_after_reset", reads_served, 32'd0);
    chk("misaligned_after_reset", {31'b0, misaligned}, 32'd0);
    issue(30'(BASE + 'h80), 2'd0, 8'h00, nw);
    chk("post_reset_no_wait", 32'(nw), 32'd0);
    drain();
    chk("post_reset_data", last_ret_dat, 32'h80818283);
    chk("post_reset_served", reads_served, 32'd1);

    // Long randomised back-to-back stream.
    r0 = n_ret;
    for (int i = 0; i < 1000; i++) begin
      issue(30'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), nw);
    end
    drain();
    chk("stream_returns", 32'(n_ret - r0), 32'd1000);
    chk("stream_served", reads_served, 32'd1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
